// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - opcodes, FSM states and decode/steering helpers for the MEM-stage sequencer
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWU = 6'b100111;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU, OP_SH:        return k[0];
            OP_LW, OP_LWU, OP_SW:        return k != 2'b00;
            default:                     return 1'b0;
        endcase
    endfunction

    // Loads always read the whole word; only stores narrow the enables.
    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] k);
        case (op)
            OP_SB:   return 4'b0001 << k;
            OP_SH:   return 4'b0011 << k;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the narrow datum into every lane so the enables alone pick the target bytes.
    function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - shifts the addressed byte/half down to bit 0 and sign/zero-extends it
//   opcode    : latched load opcode
//   k         : byte offset within the word
//   mem_rdata : raw word from memory
//   data      : extended load result
module load_align_ext
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  k,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data
);

    logic [31:0] word;

    assign word = mem_rdata >> {k, 3'b000};

    always_comb begin
        data = word;
        case (opcode)
            OP_LB:   data = {{24{word[7]}}, word[7:0]};
            OP_LBU:  data = {24'b0, word[7:0]};
            OP_LH:   data = {{16{word[15]}}, word[15:0]};
            OP_LHU:  data = {16'b0, word[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with req/ack memory handshake and timeout
//   clk, reset              : clock, asynchronous active-high reset
//   op_valid/opcode/addr/store_data : instruction held in EX/MEM
//   stall                   : freezes the upstream pipeline
//   load_data/load_valid    : extended load result and its strobe
//   exc_misaligned/exc_bus  : alignment fault / timeout abort pulses
//   mem_req/we/addr/be/wdata, mem_ack/rdata : single-port data memory handshake
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_misaligned,
    output logic        exc_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [1:0]        k_q, k_d;
    logic              timeout_q, timeout_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [31:0]       ext_data;
    logic              is_mem_op;
    logic              misaligned;

    assign is_mem_op  = is_load(opcode) || is_store(opcode);
    assign misaligned = is_misaligned(opcode, addr[1:0]);

    load_align_ext u_align (
        .opcode    (opcode_q),
        .k         (k_q),
        .mem_rdata (mem_rdata),
        .data      (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        opcode_d       = opcode_q;
        k_d            = k_q;
        timeout_d      = timeout_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        load_data_d    = load_data_q;
        stall          = 1'b0;
        exc_misaligned = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid && is_mem_op) begin
                    if (misaligned) begin
                        exc_misaligned = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        opcode_d    = opcode;
                        k_d         = addr[1:0];
                        timeout_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(opcode);
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = store_be(opcode, addr[1:0]);
                        mem_wdata_d = store_wdata(opcode, store_data);
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                // ack takes priority over an expiring counter in the same cycle
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (is_load(opcode_q)) begin
                        load_data_d = ext_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    timeout_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opcode_q    <= '0;
            k_q         <= '0;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            k_q         <= k_d;
            timeout_q   <= timeout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign load_valid = (state_q == DONE) && is_load(opcode_q);
    assign exc_bus    = (state_q == DONE) && timeout_q;
    assign load_data  = load_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a programmable-latency memory
module tb_mem_access_ctrl;
    import mips_mem_pkg::*;

    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        exc_misaligned;
    logic        exc_bus;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        lv;
        logic        mis;
        logic        bus;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];

    logic        resp_en = 1'b1;
    int          ack_after = 1;
    logic [31:0] rdata_cfg = '0;
    int          acc_cnt = 0;
    logic        req_prev = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .opcode         (opcode),
        .addr           (addr),
        .store_data     (store_data),
        .stall          (stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .exc_misaligned (exc_misaligned),
        .exc_bus        (exc_bus),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks on the ack_after-th ACCESS cycle; ack_after=0 never acks.
    always @(negedge clk) begin
        if (resp_en) begin
            if (mem_req) begin
                acc_cnt   = acc_cnt + 1;
                mem_ack   = (ack_after != 0) && (acc_cnt == ack_after);
                mem_rdata = rdata_cfg;
            end else begin
                acc_cnt = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: compares every response pulse and every new memory request against the queues.
    always @(negedge clk) begin
        #2;
        if (load_valid || exc_misaligned || exc_bus) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", {29'b0, load_valid, exc_misaligned, exc_bus}, 32'h0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_flags", {29'b0, load_valid, exc_misaligned, exc_bus},
                    {29'b0, e.lv, e.mis, e.bus});
                if (e.lv) chk("load_data", load_data, e.data);
            end
        end
        if (mem_req && !req_prev) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", {31'b0, mem_req}, 32'h0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                chk("mem_we", {31'b0, mem_we}, {31'b0, r.we});
                chk("mem_addr", mem_addr, r.a);
                chk("mem_be", {28'b0, mem_be}, {28'b0, r.be});
                if (r.chk_wd) chk("mem_wdata", mem_wdata, r.wd);
            end
        end
        req_prev = mem_req;
    end

    task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int ackd, input int exp_stall);
        int n;
        @(negedge clk);
        rdata_cfg  = rd;
        ack_after  = ackd;
        op_valid   = 1'b1;
        opcode     = op;
        addr       = a;
        store_data = sd;
        #1;
        n = stall ? 1 : 0;
        @(negedge clk);
        op_valid = 1'b0;
        opcode   = '0;
        #1;
        for (int c = 0; c < 300 && stall; c++) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({name, "_stall"}, n, exp_stall);
    endtask

    function automatic req_t ld_req(input logic [31:0] a);
        return '{we: 1'b0, a: a, be: 4'b1111, wd: 32'h0, chk_wd: 1'b0};
    endfunction

    function automatic rsp_t lv_rsp(input logic [31:0] d);
        return '{lv: 1'b1, mis: 1'b0, bus: 1'b0, data: d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {27'b0, stall, load_valid, exc_misaligned, exc_bus, mem_req}, 32'h0);
        chk("rst_ctl", {27'b0, mem_we, mem_be}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        req_q.push_back(ld_req(32'h0000_0100)); rsp_q.push_back(lv_rsp(32'hFFFF_FF80));
        issue("lb", OP_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 2);

        req_q.push_back(ld_req(32'h0000_0200)); rsp_q.push_back(lv_rsp(32'h0000_BEEF));
        issue("lhu", OP_LHU, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 2, 3);

        req_q.push_back(ld_req(32'h0000_0200)); rsp_q.push_back(lv_rsp(32'hFFFF_BEEF));
        issue("lh", OP_LH, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 1, 2);

        req_q.push_back(ld_req(32'h0000_0200)); rsp_q.push_back(lv_rsp(32'hBEEF_1234));
        issue("lw", OP_LW, 32'h0000_0200, 32'h0, 32'hBEEF_1234, 3, 4);

        req_q.push_back(ld_req(32'h0000_0100)); rsp_q.push_back(lv_rsp(32'h0000_0056));
        issue("lbu", OP_LBU, 32'h0000_0101, 32'h0, 32'h1234_5678, 1, 2);

        req_q.push_back('{we: 1'b1, a: 32'h0000_0100, be: 4'b0010, wd: 32'hABAB_ABAB, chk_wd: 1'b1});
        issue("sb", OP_SB, 32'h0000_0101, 32'h0000_00AB, 32'h0, 1, 2);

        req_q.push_back('{we: 1'b1, a: 32'h0000_0100, be: 4'b1100, wd: 32'hCAFE_CAFE, chk_wd: 1'b1});
        issue("sh", OP_SH, 32'h0000_0102, 32'h0000_CAFE, 32'h0, 2, 3);

        req_q.push_back('{we: 1'b1, a: 32'h0000_0204, be: 4'b1111, wd: 32'h1122_3344, chk_wd: 1'b1});
        issue("sw", OP_SW, 32'h0000_0204, 32'h1122_3344, 32'h0, 1, 2);

        rsp_q.push_back('{lv: 1'b0, mis: 1'b1, bus: 1'b0, data: 32'h0});
        issue("lw_mis", OP_LW, 32'h0000_0202, 32'h0, 32'h0, 1, 0);

        rsp_q.push_back('{lv: 1'b0, mis: 1'b1, bus: 1'b0, data: 32'h0});
        issue("lh_mis", OP_LH, 32'h0000_0203, 32'h0, 32'h0, 1, 0);

        rsp_q.push_back('{lv: 1'b0, mis: 1'b1, bus: 1'b0, data: 32'h0});
        issue("sh_mis", OP_SH, 32'h0000_0101, 32'h0, 32'h0, 1, 0);

        issue("addi", OP_ADDI, 32'h0000_0200, 32'h0, 32'h0, 1, 0);

        req_q.push_back(ld_req(32'h0000_0300));
        rsp_q.push_back('{lv: 1'b1, mis: 1'b0, bus: 1'b1, data: 32'h0});
        issue("lw_tmo", OP_LW, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 0, 5);

        req_q.push_back(ld_req(32'h0000_0300)); rsp_q.push_back(lv_rsp(32'hDEAD_BEEF));
        issue("lw_ack4", OP_LW, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 4, 5);

        req_q.push_back('{we: 1'b1, a: 32'h0000_0304, be: 4'b1111, wd: 32'h5555_AAAA, chk_wd: 1'b1});
        rsp_q.push_back('{lv: 1'b0, mis: 1'b0, bus: 1'b1, data: 32'h0});
        issue("sw_tmo", OP_SW, 32'h0000_0304, 32'h5555_AAAA, 32'h0, 0, 5);

        // Reset in the middle of an access, then a late ack that must be ignored.
        resp_en = 1'b0;
        mem_ack = 1'b0;
        req_q.push_back(ld_req(32'h0000_0400));
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = OP_LW;
        addr     = 32'h0000_0400;
        @(negedge clk);
        op_valid = 1'b0;
        opcode   = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mid_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_stall", {31'b0, stall}, 32'h0);
        chk("late_ack_req", {31'b0, mem_req}, 32'h0);
        repeat (3) @(negedge clk);
        resp_en = 1'b1;

        // Pipeline still usable after the reset.
        req_q.push_back(ld_req(32'h0000_0500)); rsp_q.push_back(lv_rsp(32'h0000_0034));
        issue("lbu_post_rst", OP_LBU, 32'h0000_0502, 32'h0, 32'h0034_0000, 1, 2);

        repeat (4) @(negedge clk);
        chk("rsp_q_empty", rsp_q.size(), 32'h0);
        chk("req_q_empty", req_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage load/store sequencer for the 5-stage MIPS pipeline. Accepts the memory opcode, address and store data from the EX/MEM register, drives a variable-latency single-port data memory through a req/ack handshake, and stalls the pipeline until the access finishes. It performs byte-lane steering and alignment checks, and sign- or zero-extends load data before it goes to MEM/WB. It also bounds every access with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles before the access is aborted; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op_valid  in  1  EX/MEM holds a valid instruction
- opcode  in  6  instruction[31:26]
- addr  in  32  effective address
- store_data  in  32  rt value
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- load_data  out  32  extended load result, registered
- load_valid  out  1  one-cycle pulse; load_data is valid
- exc_misaligned  out  1  one-cycle pulse; alignment fault, no access issued
- exc_bus  out  1  one-cycle pulse; timeout abort
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr  out  32  word address: {addr[31:2],2'b00}
- mem_be  out  4  byte enables; lane k = bits [8k+7:8k]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  completes the request; sampled only in ACCESS
- mem_rdata  in  32  read word; valid with mem_ack

## Operation
- Byte order is little-endian within a word: byte offset k = addr[1:0].
- Opcodes:
  - LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LWU 100111 (LWU behaves as LW).
  - SB 101000, SH 101001, SW 101011.
  - Any other opcode is a non-memory op: no effect, stall=0.
- Alignment faults: half-word ops with addr[0]=1; word ops with addr[1:0]≠0.
- States:
  - IDLE:
    - op_valid and mem op, aligned: latch mem_* fields, assert stall, go to ACCESS.
    - op_valid and mem op, misaligned: pulse exc_misaligned, stall=0, stay in IDLE.
  - ACCESS:
    - Hold mem_req=1 and all mem_* stable; stall=1; the timeout counter increments.
    - mem_ack=1: go to DONE. For loads, register load_data.
    - Counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE, pulse exc_bus, load_data=0.
  - DONE: mem_req=0, stall=0, load_valid=1 if the op was a load. The pipeline advances at the end of this cycle; go to IDLE. No new op is started in DONE.
- Store steering:
  - SB: be=4'b0001<<k, wdata={4{store_data[7:0]}}.
  - SH: be=4'b0011<<k, wdata={2{store_data[15:0]}}.
  - SW: be=4'b1111, wdata=store_data.
- Load steering: word=mem_rdata>>(8·k).
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
- Loads drive mem_be=4'b1111 and mem_we=0.
- mem_ack outside ACCESS is ignored.
- Reset, including mid-ACCESS: return to IDLE at once and drop mem_req. A late ack is ignored and no pulse is produced.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- stall is combinational from state and the IDLE decode. mem_* outputs are registered.
- Op in IDLE at cycle N:
  - mem_req rises at N+1.
  - ack at cycle M≥N+1 gives DONE at M+1, with load_data/load_valid valid in M+1.
  - Minimum stall: 2 cycles (N and N+1).
- Timeout: ack absent for TIMEOUT_CYCLES ACCESS cycles → DONE with exc_bus in the following cycle.
- ack in the same cycle the counter expires: ack wins and exc_bus stays 0.
- Back-to-back mem ops: the second op is seen in IDLE in the cycle after DONE. There is no overlap.

## Structure
- Package mips_mem_pkg holds:
  - opcode localparams;
  - state enum {IDLE, ACCESS, DONE};
  - functions is_load, is_store, is_misaligned.
- Sub-module load_align_ext (combinational): inputs opcode, k, mem_rdata; output 32-bit extended data. It is instantiated once and feeds the load_data register.
- Counter width: 8 bits.

## Test plan
- LB at addr 0x103, mem_rdata=0x80FF_0000, ack after 1 cycle → load_data=0xFFFF_FF80; stall high 2 cycles; load_valid pulse in DONE.
- LHU at 0x202, rdata=0xBEEF_1234 → 0x0000_BEEF. LH same → 0xFFFF_BEEF. LW at 0x200 → 0xBEEF_1234.
- SB at 0x101 with store_data=0x0000_00AB → mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x100. SH at 0x102 → be=1100.
- LW at 0x202 → exc_misaligned pulse, mem_req never rises, stall=0. Opcode 001000 (ADDI) → no activity.
- ack withheld, TIMEOUT_CYCLES=4 → exc_bus pulse after 4 ACCESS cycles, load_data=0, stall released. Repeat with ack on the 4th cycle → no exc_bus.
- reset asserted mid-ACCESS, then ack after reset release → mem_req=0 immediately, state IDLE, no load_valid.
